mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Two-master, one-slave arbiter for the core's single memory port. Master 0 is IFU fetch (read-only); master 1 is EXU/LSU data (read/write).
//  Round-robin grant, one outstanding transaction at a time, valid/ready on request and response channels.
//  Watchdog converts a hung slave into an error response so the EXU EXEC state always exits.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width; wmask width = DATA_W/8
//  TMO_CYC  255  max cycles in REQ+WAIT before watchdog fires (1..2^16-1)
// PORTS
//  clk            in   1       single clock, posedge
//  rst_n          in   1       asynchronous, active-low reset
//  ifu_req_valid  in   1       fetch request
//  ifu_req_addr   in   ADDR_W  fetch address
//  ifu_req_ready  out  1       fetch request accepted this cycle
//  ifu_rsp_valid  out  1       fetch data valid (1-cycle pulse)
//  ifu_rsp_rdata  out  DATA_W  fetch data
//  lsu_req_valid  in   1       data request
//  lsu_req_addr   in   ADDR_W  data address
//  lsu_req_wen    in   1       1 = store, 0 = load
//  lsu_req_wdata  in   DATA_W  store data
//  lsu_req_wmask  in   DATA_W/8 byte enables
//  lsu_req_ready  out  1       data request accepted this cycle
//  lsu_rsp_valid  out  1       data response valid (1-cycle pulse; stores too)
//  lsu_rsp_rdata  out  DATA_W  load data
//  mem_req_valid  out  1       slave request
//  mem_req_addr   out  ADDR_W
//  mem_req_wen    out  1
//  mem_req_wdata  out  DATA_W
//  mem_req_wmask  out  DATA_W/8
//  mem_req_ready  in   1       slave accepts request
//  mem_rsp_valid  in   1       slave response
//  mem_rsp_rdata  in   DATA_W
//  rsp_err        out  1       qualifies ifu/lsu_rsp_valid: 1 = watchdog timeout
//  owner          out  1       0 = IFU, 1 = LSU (last/current grant)
//  state_out      out  2       current FSM state
// BEHAVIOUR
//  - States: IDLE=2'b00, REQ=2'b01, WAIT=2'b10; 2'b11 is illegal and goes to IDLE.
//  - Reset: state=IDLE, owner=1 (IFU wins the first tie), all valid/ready outputs 0, data/addr outputs 0, watchdog=0.
//  - IDLE: ready outputs are combinational. Only the granted master's ready=1, and only when its valid=1.
//    - One requester: that requester is granted.
//    - Both requesting: the master != owner is granted (round-robin).
//    - On acceptance: latch addr/wen/wdata/wmask and set owner. IFU requests force wen=0 and wmask=0. Next state = REQ.
//  - REQ: mem_req_valid=1 with the latched fields held stable. If mem_req_ready=1, go to WAIT next cycle.
//    - If mem_req_ready and mem_rsp_valid are both 1 in the same cycle, the response is taken at once and the FSM goes straight to IDLE.
//  - WAIT: mem_req_valid=0. On mem_rsp_valid=1, the owner's rsp_valid pulses for 1 cycle next cycle, with rdata registered and rsp_err=0. Then IDLE.
//    - The non-owner rsp_valid is never asserted.
//  - Latency with a zero-wait slave: accept at cycle N, mem_req_valid at N+1, response at N+2, rsp_valid at N+3.
//  - No new acceptance in the cycle rsp_valid is high. The earliest next acceptance is that same cycle + 1 (ready is low during REQ/WAIT).
//  - Watchdog: counts cycles in REQ or WAIT and clears in IDLE.
//    - When the count reaches TMO_CYC: rsp_valid to the owner with rsp_err=1, rdata=0. Go to IDLE and drop mem_req_valid.
//    - A late mem_rsp_valid arriving in IDLE is ignored.
//  - mem_rsp_valid outside WAIT (and outside the REQ shortcut) is ignored.
//  - Requester valid dropping after acceptance has no effect; the transaction completes.
//  - rst_n low mid-transaction: immediate return to reset values. No response pulse is generated.
// TESTING
//  - IFU only, addr=0x8000_0000, slave returns 0xDEAD_BEEF with zero wait -> ifu_rsp_valid at cycle 3 after accept, rdata=0xDEADBEEF, rsp_err=0.
//  - Both valid every cycle from reset -> grants alternate IFU, LSU, IFU, LSU; never two ready outputs in one cycle.
//  - LSU store addr=0x8000_0010, wdata=0x1234_5678, wmask=4'b0011 -> mem_req_* carry these exact values, wen=1; lsu_rsp_valid pulses once.
//  - Slave holds mem_req_ready=0 for 3 cycles -> mem_req_valid and fields stable for 4 cycles; no response until ready.
//  - TMO_CYC=8, slave never responds -> rsp_valid+rsp_err=1 after 8 cycles in REQ; state IDLE; a later mem_rsp_valid is ignored.
//  - rst_n asserted while in WAIT -> state_out=00, mem_req_valid=0, no rsp_valid pulse; after release, IFU wins the first tie.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master (IFU fetch, LSU data) round-robin arbiter onto the core's single memory port.
// One transaction in flight at a time; a watchdog turns a hung slave into an error response.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ifu_req_valid,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_req_ready,
    output logic                  ifu_rsp_valid,
    output logic [DATA_W-1:0]     ifu_rsp_rdata,

    input  logic                  lsu_req_valid,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wmask,
    output logic                  lsu_req_ready,
    output logic                  lsu_rsp_valid,
    output logic [DATA_W-1:0]     lsu_rsp_rdata,

    output logic                  mem_req_valid,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_rdata,

    output logic                  rsp_err,
    output logic                  owner,
    output logic [1:0]            state_out
);

    localparam int MASK_W = DATA_W / 8;
    localparam int WDOG_W = 16;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
    logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                grant_lsu;
    logic                can_accept;
    logic                wdog_fire;
    logic                done;
    logic                done_err;
    logic [DATA_W-1:0]   done_data;

    // On a tie the master that was not served last wins; owner resets to LSU so IFU wins first.
    always_comb begin
        grant_lsu = lsu_req_valid;
        if (ifu_req_valid && lsu_req_valid) begin
            grant_lsu = ~owner_q;
        end
    end

    assign can_accept    = (state_q == ST_IDLE) && !(ifu_rsp_valid_q || lsu_rsp_valid_q);
    assign ifu_req_ready = can_accept && ifu_req_valid && !grant_lsu;
    assign lsu_req_ready = can_accept && lsu_req_valid && grant_lsu;
    assign wdog_fire     = (wdog_q == WDOG_LAST);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        wdog_d    = '0;
        done      = 1'b0;
        done_err  = 1'b0;
        done_data = '0;

        case (state_q)
            ST_IDLE: begin
                if (ifu_req_ready) begin
                    addr_d  = ifu_req_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    owner_d = 1'b0;
                    state_d = ST_REQ;
                end else if (lsu_req_ready) begin
                    addr_d  = lsu_req_addr;
                    wen_d   = lsu_req_wen;
                    wdata_d = lsu_req_wdata;
                    wmask_d = lsu_req_wmask;
                    owner_d = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                wdog_d = wdog_q + WDOG_W'(1);
                // A slave may accept and answer in the same cycle; that skips WAIT entirely.
                if (mem_req_ready && mem_rsp_valid) begin
                    done      = 1'b1;
                    done_data = mem_rsp_rdata;
                end else if (wdog_fire) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (mem_rsp_valid) begin
                    done      = 1'b1;
                    done_data = mem_rsp_rdata;
                end else if (wdog_fire) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (done) begin
            state_d = ST_IDLE;
        end

        ifu_rsp_valid_d = done && !owner_q;
        lsu_rsp_valid_d = done && owner_q;
        rsp_err_d       = done_err;
        rsp_rdata_d     = done ? done_data : rsp_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            owner_q         <= 1'b1;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            wdog_q          <= '0;
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_rdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            wdog_q          <= wdog_d;
            ifu_rsp_valid_q <= ifu_rsp_valid_d;
            lsu_rsp_valid_q <= lsu_rsp_valid_d;
            rsp_err_q       <= rsp_err_d;
            rsp_rdata_q     <= rsp_rdata_d;
        end
    end

    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

    assign ifu_rsp_valid = ifu_rsp_valid_q;
    assign lsu_rsp_valid = lsu_rsp_valid_q;
    assign ifu_rsp_rdata = rsp_rdata_q;
    assign lsu_rsp_rdata = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign owner         = owner_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a transaction-timing model checked every cycle,
// plus directed scenarios with hand-computed latencies and field values.
module tb_mem_bus_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MW  = DW / 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ifu_req_valid = 1'b0;
    logic [AW-1:0] ifu_req_addr = '0;
    logic          ifu_req_ready;
    logic          ifu_rsp_valid;
    logic [DW-1:0] ifu_rsp_rdata;
    logic          lsu_req_valid = 1'b0;
    logic [AW-1:0] lsu_req_addr = '0;
    logic          lsu_req_wen = 1'b0;
    logic [DW-1:0] lsu_req_wdata = '0;
    logic [MW-1:0] lsu_req_wmask = '0;
    logic          lsu_req_ready;
    logic          lsu_rsp_valid;
    logic [DW-1:0] lsu_rsp_rdata;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_wen;
    logic [DW-1:0] mem_req_wdata;
    logic [MW-1:0] mem_req_wmask;
    logic          mem_req_ready = 1'b0;
    logic          mem_rsp_valid = 1'b0;
    logic [DW-1:0] mem_rsp_rdata = '0;
    logic          rsp_err;
    logic          owner;
    logic [1:0]    state_out;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask), .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .rsp_err(rsp_err), .owner(owner), .state_out(state_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Slave model: stalls ready for slave_stall cycles, answers the cycle after the handshake
    int            slave_stall = 0;
    bit            slave_respond = 1'b1;
    bit            slave_shortcut = 1'b0;
    bit            slave_force = 1'b0;
    logic [DW-1:0] slave_data = 32'hDEAD_BEEF;
    int            stall_cnt = 0;
    logic          slave_hs;

    always @(posedge clk) begin
        slave_hs = mem_req_valid && mem_req_ready;
        #1;
        mem_rsp_valid = (slave_hs && slave_respond && !slave_shortcut) || slave_force;
        mem_rsp_rdata = slave_data;
        if (mem_req_valid) begin
            if (stall_cnt < slave_stall) begin
                mem_req_ready = 1'b0;
                stall_cnt++;
            end else begin
                mem_req_ready = 1'b1;
            end
        end else begin
            mem_req_ready = 1'b0;
            stall_cnt = 0;
        end
        if (slave_shortcut && slave_respond && mem_req_valid && mem_req_ready) begin
            mem_rsp_valid = 1'b1;
        end
    end

    // Transaction model: who may be accepted, how long the request is presented, when and what returns
    logic          m_busy, m_in_req, m_owner, m_from_lsu, m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;
    int            m_elapsed;
    logic          m_pulse, m_pulse_lsu, m_pulse_err;
    logic [DW-1:0] m_pulse_data;
    logic          exp_ifu_rdy, exp_lsu_rdy, m_done, m_done_err;
    logic [DW-1:0] m_done_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_in_req = 1'b0; m_owner = 1'b1; m_from_lsu = 1'b0;
            m_wen = 1'b0; m_addr = '0; m_wdata = '0; m_wmask = '0; m_elapsed = 0;
            m_pulse = 1'b0; m_pulse_lsu = 1'b0; m_pulse_err = 1'b0; m_pulse_data = '0;
        end
        exp_ifu_rdy = 1'b0;
        exp_lsu_rdy = 1'b0;
        if (rst_n && !m_busy && !m_pulse) begin
            if (ifu_req_valid && lsu_req_valid) begin
                exp_ifu_rdy = m_owner;
                exp_lsu_rdy = !m_owner;
            end else begin
                exp_ifu_rdy = ifu_req_valid;
                exp_lsu_rdy = lsu_req_valid;
            end
        end
        checkOutput("ifu_req_ready", ifu_req_ready, exp_ifu_rdy);
        checkOutput("lsu_req_ready", lsu_req_ready, exp_lsu_rdy);
        checkOutput("mem_req_valid", mem_req_valid, m_busy && m_in_req);
        checkOutput("state_out", state_out, !m_busy ? 32'd0 : (m_in_req ? 32'd1 : 32'd2));
        checkOutput("owner", owner, m_owner);
        checkOutput("ifu_rsp_valid", ifu_rsp_valid, m_pulse && !m_pulse_lsu);
        checkOutput("lsu_rsp_valid", lsu_rsp_valid, m_pulse && m_pulse_lsu);
        checkOutput("rsp_err", rsp_err, m_pulse && m_pulse_err);
        if (m_pulse) begin
            checkOutput("rsp_rdata", m_pulse_lsu ? lsu_rsp_rdata : ifu_rsp_rdata, m_pulse_data);
        end
        if (m_busy && m_in_req) begin
            checkOutput("mem_req_addr", mem_req_addr, m_addr);
            checkOutput("mem_req_wen", mem_req_wen, m_wen);
            checkOutput("mem_req_wmask", mem_req_wmask, m_wmask);
            if (m_from_lsu) checkOutput("mem_req_wdata", mem_req_wdata, m_wdata);
        end
        if (!rst_n) begin
            checkOutput("reset_addr", mem_req_addr, 0);
            checkOutput("reset_wdata", mem_req_wdata, 0);
            checkOutput("reset_rdata", ifu_rsp_rdata, 0);
        end

        if (rst_n) begin
            m_done = 1'b0; m_done_err = 1'b0; m_done_data = '0;
            if (m_busy) begin
                m_elapsed++;
                if (m_in_req && mem_req_ready && mem_rsp_valid) begin
                    m_done = 1'b1; m_done_data = mem_rsp_rdata;
                end else if (m_in_req && mem_req_ready) begin
                    m_in_req = 1'b0;
                end else if (!m_in_req && mem_rsp_valid) begin
                    m_done = 1'b1; m_done_data = mem_rsp_rdata;
                end
                if (!m_done && m_elapsed == TMO) begin
                    m_done = 1'b1; m_done_err = 1'b1; m_done_data = '0;
                end
                if (m_done) begin
                    m_busy = 1'b0; m_in_req = 1'b0;
                end
            end else if (exp_ifu_rdy || exp_lsu_rdy) begin
                m_busy = 1'b1; m_in_req = 1'b1; m_elapsed = 0;
                m_owner = exp_lsu_rdy; m_from_lsu = exp_lsu_rdy;
                m_addr  = exp_lsu_rdy ? lsu_req_addr : ifu_req_addr;
                m_wen   = exp_lsu_rdy ? lsu_req_wen : 1'b0;
                m_wdata = exp_lsu_rdy ? lsu_req_wdata : '0;
                m_wmask = exp_lsu_rdy ? lsu_req_wmask : '0;
            end
            m_pulse = m_done; m_pulse_lsu = m_owner; m_pulse_err = m_done_err; m_pulse_data = m_done_data;
        end
    end

    task automatic applyStimulus(input logic iv, input logic [AW-1:0] ia, input logic lv,
                                 input logic [AW-1:0] la, input logic wen,
                                 input logic [DW-1:0] wd, input logic [MW-1:0] wm);
        @(posedge clk);
        #1;
        ifu_req_valid = iv; ifu_req_addr = ia;
        lsu_req_valid = lv; lsu_req_addr = la; lsu_req_wen = wen;
        lsu_req_wdata = wd; lsu_req_wmask = wm;
    endtask

    task automatic setSlave(input int stall, input bit respond, input bit shortcut,
                            input bit force_rsp, input logic [DW-1:0] data);
        @(negedge clk);
        slave_stall = stall; slave_respond = respond; slave_shortcut = shortcut;
        slave_force = force_rsp; slave_data = data;
    endtask

    task automatic waitAccept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifu_req_ready || lsu_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("accept_seen", ok, 1);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int            cap_lat, cap_req_cycles, cap_ifu_pulses, cap_lsu_pulses;
    logic [DW-1:0] cap_rdata, cap_wdata;
    logic [AW-1:0] cap_addr;
    logic [MW-1:0] cap_wmask;
    logic          cap_err, cap_wen, cap_req_valid_at_rsp;
    logic [1:0]    cap_state_at_rsp;

    // One single-master transaction; latency is counted in cycles after the accepting cycle
    task automatic doTxn(input logic use_lsu, input logic [AW-1:0] addr, input logic wen,
                         input logic [DW-1:0] wd, input logic [MW-1:0] wm);
        bit ok;
        cap_lat = 0; cap_req_cycles = 0; cap_ifu_pulses = 0; cap_lsu_pulses = 0;
        if (use_lsu) applyStimulus(1'b0, '0, 1'b1, addr, wen, wd, wm);
        else         applyStimulus(1'b1, addr, 1'b0, '0, 1'b0, '0, '0);
        waitAccept(ok);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        if (!ok) return;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (mem_req_valid) begin
                if (cap_req_cycles == 0) begin
                    cap_addr = mem_req_addr; cap_wen = mem_req_wen;
                    cap_wdata = mem_req_wdata; cap_wmask = mem_req_wmask;
                end
                cap_req_cycles++;
            end
            if (ifu_rsp_valid) cap_ifu_pulses++;
            if (lsu_rsp_valid) cap_lsu_pulses++;
            if ((ifu_rsp_valid || lsu_rsp_valid) && cap_lat == 0) begin
                cap_lat = i;
                cap_rdata = ifu_rsp_valid ? ifu_rsp_rdata : lsu_rsp_rdata;
                cap_err = rsp_err;
                cap_state_at_rsp = state_out;
                cap_req_valid_at_rsp = mem_req_valid;
            end
            if (cap_lat != 0 && i >= cap_lat + 4) break;
        end
    endtask

    int   grants[$];
    int   both_ready;
    int   pulses;
    bit   ok;
    bit   found;

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_state", state_out, 2'b00);
        checkOutput("reset_owner", owner, 1'b1);
        checkOutput("reset_mem_req_valid", mem_req_valid, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] IFU fetch, zero-wait slave");
        setSlave(0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        doTxn(1'b0, 32'h8000_0000, 1'b0, '0, '0);
        checkOutput("ifu_latency", cap_lat, 3);
        checkOutput("ifu_rdata", cap_rdata, 32'hDEAD_BEEF);
        checkOutput("ifu_err", cap_err, 1'b0);
        checkOutput("ifu_addr", cap_addr, 32'h8000_0000);
        checkOutput("ifu_forced_wen", cap_wen, 1'b0);
        checkOutput("ifu_forced_wmask", cap_wmask, 4'b0000);
        checkOutput("ifu_pulses", cap_ifu_pulses, 1);
        checkOutput("ifu_no_lsu_pulse", cap_lsu_pulses, 0);

        $display("[TB] both masters requesting from reset");
        doReset();
        grants.delete();
        both_ready = 0;
        applyStimulus(1'b1, 32'h8000_0040, 1'b1, 32'h8000_0080, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifu_req_ready && lsu_req_ready) both_ready++;
            else if (ifu_req_ready) grants.push_back(0);
            else if (lsu_req_ready) grants.push_back(1);
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        repeat (10) @(negedge clk);
        checkOutput("rr_both_ready", both_ready, 0);
        checkOutput("rr_grant_count_ge4", grants.size() >= 4, 1);
        if (grants.size() >= 4) begin
            checkOutput("rr_grant0", grants[0], 0);
            checkOutput("rr_grant1", grants[1], 1);
            checkOutput("rr_grant2", grants[2], 0);
            checkOutput("rr_grant3", grants[3], 1);
        end

        $display("[TB] LSU store");
        setSlave(0, 1'b1, 1'b0, 1'b0, 32'hCAFE_0001);
        doTxn(1'b1, 32'h8000_0010, 1'b1, 32'h1234_5678, 4'b0011);
        checkOutput("store_addr", cap_addr, 32'h8000_0010);
        checkOutput("store_wdata", cap_wdata, 32'h1234_5678);
        checkOutput("store_wmask", cap_wmask, 4'b0011);
        checkOutput("store_wen", cap_wen, 1'b1);
        checkOutput("store_lsu_pulses", cap_lsu_pulses, 1);
        checkOutput("store_no_ifu_pulse", cap_ifu_pulses, 0);
        checkOutput("store_latency", cap_lat, 3);

        $display("[TB] slave stalls ready for 3 cycles");
        setSlave(3, 1'b1, 1'b0, 1'b0, 32'h5555_AAAA);
        doTxn(1'b0, 32'h8000_0100, 1'b0, '0, '0);
        checkOutput("stall_req_cycles", cap_req_cycles, 4);
        checkOutput("stall_latency", cap_lat, 6);
        checkOutput("stall_rdata", cap_rdata, 32'h5555_AAAA);

        $display("[TB] accept and respond in the same cycle");
        setSlave(0, 1'b1, 1'b1, 1'b0, 32'h0BAD_F00D);
        doTxn(1'b1, 32'h8000_0020, 1'b0, '0, 4'hF);
        checkOutput("shortcut_latency", cap_lat, 2);
        checkOutput("shortcut_req_cycles", cap_req_cycles, 1);
        checkOutput("shortcut_rdata", cap_rdata, 32'h0BAD_F00D);
        checkOutput("shortcut_lsu_pulses", cap_lsu_pulses, 1);

        $display("[TB] hung slave, watchdog");
        setSlave(1000, 1'b0, 1'b0, 1'b0, 32'h7777_7777);
        doTxn(1'b1, 32'h8000_0030, 1'b0, '0, 4'hF);
        checkOutput("tmo_latency", cap_lat, TMO + 1);
        checkOutput("tmo_req_cycles", cap_req_cycles, TMO);
        checkOutput("tmo_err", cap_err, 1'b1);
        checkOutput("tmo_rdata", cap_rdata, 32'h0);
        checkOutput("tmo_state", cap_state_at_rsp, 2'b00);
        checkOutput("tmo_req_valid_dropped", cap_req_valid_at_rsp, 1'b0);
        checkOutput("tmo_lsu_pulses", cap_lsu_pulses, 1);
        setSlave(1000, 1'b0, 1'b0, 1'b1, 32'h7777_7777);
        setSlave(1000, 1'b0, 1'b0, 1'b0, 32'h7777_7777);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ifu_rsp_valid || lsu_rsp_valid) pulses++;
        end
        checkOutput("late_rsp_ignored", pulses, 0);
        checkOutput("late_rsp_state", state_out, 2'b00);

        $display("[TB] reset while waiting for the slave");
        setSlave(0, 1'b0, 1'b0, 1'b0, 32'h1111_2222);
        applyStimulus(1'b1, 32'h8000_0200, 1'b0, '0, 1'b0, '0, '0);
        waitAccept(ok);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (state_out == 2'b10) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reached_wait", found, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_state", state_out, 2'b00);
        checkOutput("midreset_mem_req_valid", mem_req_valid, 1'b0);
        checkOutput("midreset_owner", owner, 1'b1);
        pulses = (ifu_rsp_valid || lsu_rsp_valid) ? 1 : 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ifu_rsp_valid || lsu_rsp_valid) pulses++;
        end
        checkOutput("midreset_no_pulse", pulses, 0);
        setSlave(0, 1'b1, 1'b0, 1'b0, 32'h3333_4444);
        applyStimulus(1'b1, 32'h8000_0300, 1'b1, 32'h8000_0400, 1'b0, '0, 4'hF);
        waitAccept(ok);
        checkOutput("postreset_ifu_wins", ifu_req_ready, 1'b1);
        checkOutput("postreset_lsu_waits", lsu_req_ready, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL global_timeout actual=still_running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] simulation aborted");
    end

endmodule
